// File: rtl/dot_int_seq.sv
// dot_int_seq: streams k-element chunks through one dot_int and accumulates a long signed dot product.
// Ports: i_clk/i_rst (sync active-high reset); i_start/i_num_blocks/o_busy job command;
// i_valid/o_ready/i_vec_a/i_vec_b chunk stream; o_valid/i_ready/o_acc result.
// Build option: define DOT_SEQ_SAT_EN to saturate o_acc when out_width < acc_width (default wraps).
module dot_int #(
  parameter int bit_width = 8,
  parameter int k         = 32,
  parameter int dp_width  = 2*bit_width+$clog2(k)
) (
  input  logic [bit_width*k-1:0]     i_vec_a,
  input  logic [bit_width*k-1:0]     i_vec_b,
  output logic signed [dp_width-1:0] o_dp
);
  logic signed [2*bit_width-1:0] p;
  always_comb begin
    o_dp = '0;
    p = '0;
    for (int i = 0; i < k; i++) begin
      p = $signed(i_vec_a[i*bit_width +: bit_width]) * $signed(i_vec_b[i*bit_width +: bit_width]);
      o_dp = o_dp + dp_width'(p);
    end
  end
endmodule

module dot_int_seq #(
  parameter int bit_width  = 8,
  parameter int k          = 32,
  parameter int max_blocks = 64,
  parameter int dp_width   = 2*bit_width+$clog2(k),
  parameter int acc_width  = dp_width+$clog2(max_blocks),
  parameter int out_width  = acc_width
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_start,
  input  logic [$clog2(max_blocks+1)-1:0]   i_num_blocks,
  output logic                              o_busy,
  input  logic                              i_valid,
  output logic                              o_ready,
  input  logic [bit_width*k-1:0]            i_vec_a,
  input  logic [bit_width*k-1:0]            i_vec_b,
  output logic                              o_valid,
  input  logic                              i_ready,
  output logic signed [out_width-1:0]       o_acc
);
  localparam int nb_w = $clog2(max_blocks+1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t                      state_q;
  logic [nb_w-1:0]             remaining_q, nb_d;
  logic signed [acc_width-1:0] acc_q;
  logic signed [dp_width-1:0]  p1_dp_q, dp;
  logic                        p1_valid_q, hs;
  dot_int #(.bit_width(bit_width), .k(k), .dp_width(dp_width)) u_dot (
    .i_vec_a(i_vec_a),
    .i_vec_b(i_vec_b),
    .o_dp(dp)
  );
  assign hs   = i_valid && o_ready;
  assign nb_d = i_num_blocks > nb_w'(max_blocks) ? nb_w'(max_blocks) : i_num_blocks;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      acc_q       <= '0;
      p1_dp_q     <= '0;
      p1_valid_q  <= 1'b0;
      o_busy      <= 1'b0;
      o_ready     <= 1'b0;
      o_valid     <= 1'b0;
    end else begin
      p1_valid_q <= hs;
      if (hs) p1_dp_q <= dp;
      if (p1_valid_q) acc_q <= acc_q + acc_width'(p1_dp_q);
      case (state_q)
        IDLE: if (i_start) begin
          remaining_q <= nb_d;
          acc_q       <= '0;
          state_q     <= nb_d == '0 ? DONE : RUN;
          o_busy      <= 1'b1;
          o_ready     <= nb_d != '0;
          o_valid     <= nb_d == '0;
        end
        RUN: if (hs) begin
          remaining_q <= remaining_q - 1'b1;
          if (remaining_q == nb_w'(1)) begin
            state_q <= DRAIN;
            o_ready <= 1'b0;
          end
        end
        DRAIN: begin
          state_q <= DONE;
          o_valid <= 1'b1;
        end
        DONE: if (i_ready) begin
          state_q <= IDLE;
          o_busy  <= 1'b0;
          o_valid <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`ifdef DOT_SEQ_SAT_EN
  if (out_width < acc_width) begin : g_sat
    // In range only when every bit above the output sign bit matches it.
    logic [acc_width-out_width:0] hi;
    assign hi    = acc_q[acc_width-1:out_width-1];
    assign o_acc = (&hi || ~|hi) ? acc_q[out_width-1:0]
                 : {acc_q[acc_width-1], {(out_width-1){~acc_q[acc_width-1]}}};
  end else begin : g_full
    assign o_acc = acc_q[out_width-1:0];
  end
`else
  assign o_acc = acc_q[out_width-1:0];
`endif
endmodule
